// File: rtl/shifter_seq_if.sv
// shifter_seq_if: start/ready/done handshake plus operand and result bus for shifter_seq
interface shifter_seq_if #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5
);
   logic               start_i;
   logic [1:0]         mode_i;
   logic [WIDTH-1:0]   data_i;
   logic [SHAMT_W-1:0] shamt_i;
   logic               ready_o;
   logic               busy_o;
   logic               done_o;
   logic [WIDTH-1:0]   data_o;
   modport master (output start_i, mode_i, data_i, shamt_i, input ready_o, busy_o, done_o, data_o);
   modport slave  (input start_i, mode_i, data_i, shamt_i, output ready_o, busy_o, done_o, data_o);
endinterface

// File: rtl/shifter_seq.sv
// shifter_seq: multi-cycle SLL/SRL/SRA/ROL shifter moving up to STEP bits per cycle
module shifter_seq #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5,
   parameter int STEP    = 1
) (
   input logic          clk_i,
   input logic          rst_i,
   shifter_seq_if.slave bus
);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t             state, state_nxt;
   logic [1:0]         mode;
   logic [WIDTH-1:0]   work, work_nxt, shifted;
   logic [SHAMT_W-1:0] rem, rem_nxt, k;
   logic               accept;
   assign accept = state == IDLE && bus.start_i;
   // state register
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) state <= IDLE;
      else state <= state_nxt;
   // one shift step of k bits in the latched mode; k never reaches WIDTH since rem < WIDTH
   always_comb begin
      k = int'(rem) < STEP ? rem : SHAMT_W'(STEP);
      shifted = mode == 2'b00 ? work << k :
                mode == 2'b01 ? work >> k :
                mode == 2'b10 ? WIDTH'($signed(work) >>> k) :
                (work << k) | (work >> (WIDTH - int'(k)));
   end
   // next state and next work/remaining values; rem==0 after latch skips SHIFT
   always_comb begin
      work_nxt = accept ? bus.data_i : state == SHIFT ? shifted : work;
      rem_nxt = accept ? bus.shamt_i : state == SHIFT ? rem - k : rem;
      state_nxt = state == DONE ? IDLE :
                  (accept || state == SHIFT) ? (rem_nxt == '0 ? DONE : SHIFT) :
                  state;
   end
   // operand registers, latched on acceptance and stepped while shifting
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         work <= '0;
         rem <= '0;
         mode <= '0;
      end else begin
         work <= work_nxt;
         rem <= rem_nxt;
         mode <= accept ? bus.mode_i : mode;
      end
   // result register, loaded on entry to DONE so data_o is valid alongside done_o
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) bus.data_o <= '0;
      else if (state_nxt == DONE) bus.data_o <= work_nxt;
   // handshake outputs decoded from state
   always_comb begin
      bus.ready_o = state == IDLE;
      bus.busy_o = state != IDLE;
      bus.done_o = state == DONE;
   end
endmodule

// File: tb/tb_shifter_seq.sv
// tb_shifter_seq: runs STEP=1, STEP=4 and STEP=32 shifters in lockstep against a reference model
module tb_shifter_seq;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   shifter_seq_if #(.WIDTH(32), .SHAMT_W(5)) b0 ();
   shifter_seq_if #(.WIDTH(32), .SHAMT_W(5)) b1 ();
   shifter_seq_if #(.WIDTH(32), .SHAMT_W(5)) b2 ();
   shifter_seq #(.WIDTH(32), .SHAMT_W(5), .STEP(1))  u0 (.clk_i(clk), .rst_i(rst), .bus(b0));
   shifter_seq #(.WIDTH(32), .SHAMT_W(5), .STEP(4))  u1 (.clk_i(clk), .rst_i(rst), .bus(b1));
   shifter_seq #(.WIDTH(32), .SHAMT_W(5), .STEP(32)) u2 (.clk_i(clk), .rst_i(rst), .bus(b2));
   assign b1.start_i = b0.start_i;
   assign b1.mode_i  = b0.mode_i;
   assign b1.data_i  = b0.data_i;
   assign b1.shamt_i = b0.shamt_i;
   assign b2.start_i = b0.start_i;
   assign b2.mode_i  = b0.mode_i;
   assign b2.data_i  = b0.data_i;
   assign b2.shamt_i = b0.shamt_i;
   logic        rdy [3];
   logic        bsy [3];
   logic        dn  [3];
   logic [31:0] dout[3];
   assign rdy[0] = b0.ready_o;
   assign rdy[1] = b1.ready_o;
   assign rdy[2] = b2.ready_o;
   assign bsy[0] = b0.busy_o;
   assign bsy[1] = b1.busy_o;
   assign bsy[2] = b2.busy_o;
   assign dn[0] = b0.done_o;
   assign dn[1] = b1.done_o;
   assign dn[2] = b2.done_o;
   assign dout[0] = b0.data_o;
   assign dout[1] = b1.data_o;
   assign dout[2] = b2.data_o;
   int steps[3] = '{1, 4, 32};
   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] want);
      checks++;
      assert (obs === want) else begin
         failures++;
         $error("FAIL %s step=%0d observed=%h expected=%h", tag, steps[i], obs, want);
      end
   endtask

   function automatic logic [31:0] ref_shift(input logic [1:0] m, input logic [31:0] d, input int s);
      logic [31:0] ones = 32'hFFFF_FFFF;
      case (m)
         2'b00:   return d << s;
         2'b01:   return d >> s;
         2'b10:   return (d >> s) | (d[31] ? ~(ones >> s) : 32'h0);
         default: return s == 0 ? d : (d << s) | (d >> (32 - s));
      endcase
   endfunction

   task automatic check_idle(input string tag, input logic [31:0] want);
      for (int i = 0; i < 3; i++) begin
         chk({tag, "_ready"}, i, 32'(rdy[i]), 32'd1);
         chk({tag, "_busy"}, i, 32'(bsy[i]), 32'd0);
         chk({tag, "_done"}, i, 32'(dn[i]), 32'd0);
         chk({tag, "_data"}, i, dout[i], want);
      end
   endtask

   // one request; with noise the inputs are scrambled and start_i pulsed while every instance is busy
   task automatic run_op(input logic [1:0] m, input logic [31:0] d, input int s, input bit noise);
      logic [31:0] want = ref_shift(m, d, s);
      int lat[3];
      int cmin = 99;
      int cmax = 0;
      for (int i = 0; i < 3; i++) begin
         lat[i] = (s + steps[i] - 1) / steps[i];
         cmin = lat[i] < cmin ? lat[i] : cmin;
         cmax = lat[i] > cmax ? lat[i] : cmax;
      end
      @(negedge clk);
      for (int i = 0; i < 3; i++) chk("ready_before", i, 32'(rdy[i]), 32'd1);
      b0.start_i = 1'b1;
      b0.mode_i = m;
      b0.data_i = d;
      b0.shamt_i = 5'(s);
      for (int n = 0; n <= cmax + 1; n++) begin
         @(negedge clk);
         b0.start_i = noise && n <= cmin ? 1'($urandom) : 1'b0;
         if (noise) begin
            b0.mode_i = 2'($urandom);
            b0.data_i = $urandom;
            b0.shamt_i = 5'($urandom);
         end
         for (int i = 0; i < 3; i++) begin
            chk("busy", i, 32'(bsy[i]), 32'(n <= lat[i]));
            chk("ready", i, 32'(rdy[i]), 32'(n > lat[i]));
            chk("done", i, 32'(dn[i]), 32'(n == lat[i]));
            if (n >= lat[i]) chk("data", i, dout[i], want);
         end
      end
      b0.start_i = 1'b0;
   endtask

   initial begin
      b0.start_i = 1'b0;
      b0.mode_i = 2'b00;
      b0.data_i = 32'h0;
      b0.shamt_i = 5'd0;
      #1;
      check_idle("reset", 32'h0);
      @(negedge clk);
      rst = 1'b0;
      check_idle("post_reset", 32'h0);
      run_op(2'b00, 32'h0000_0001, 2, 1'b0);
      run_op(2'b10, 32'h8000_0000, 4, 1'b0);
      run_op(2'b01, 32'h8000_0000, 4, 1'b0);
      run_op(2'b11, 32'h8000_0001, 1, 1'b0);
      run_op(2'b11, 32'h8000_0001, 31, 1'b0);
      for (int m = 0; m < 4; m++) run_op(2'(m), 32'h1234_5678, 0, 1'b0);
      run_op(2'b01, 32'hFFFF_FFFF, 31, 1'b0);
      run_op(2'b10, 32'h7FFF_0000, 31, 1'b1);
      run_op(2'b00, 32'h0000_ABCD, 7, 1'b1);
      @(negedge clk);
      b0.start_i = 1'b1;
      b0.mode_i = 2'b00;
      b0.data_i = 32'hDEAD_BEEF;
      b0.shamt_i = 5'd20;
      @(negedge clk);
      b0.start_i = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      check_idle("mid_reset", 32'h0);
      @(negedge clk);
      rst = 1'b0;
      repeat (25) @(negedge clk);
      check_idle("after_abort", 32'h0);
      run_op(2'b11, 32'hCAFE_F00D, 13, 1'b0);
      for (int r = 0; r < 30; r++)
         run_op(2'($urandom), $urandom, int'($urandom_range(0, 31)), 1'($urandom));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
